// File: rtl/exe_pkg.sv
// Shared definitions for the execute-stage issue controller and its scoreboard.
package exe_pkg;

  // Issue controller states: IDLE = hold empty, HOLD = hold full, DRAIN = waiting for in-flight ops to retire
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } issue_state_e;

  // Width of the in-flight counter, wide enough to hold the value max_inflight itself
  function automatic int inflight_w(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/exe_scoreboard.sv
// Register busy scoreboard: a set marks a destination pending, a clear retires it.
// A set and a clear of the same entry in one cycle leave it set; entry 0 is never busy.
module exe_scoreboard #(
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  output logic [REG_COUNT-1:0]  busy
);

  logic [REG_COUNT-1:0] busy_r;
  logic [REG_COUNT-1:0] busy_nxt_s;

  // Next scoreboard value: set wins over clear, entry 0 pinned low
  always_comb begin
    busy_nxt_s = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      busy_nxt_s[i] = (set_en && (set_idx == ADDR_WIDTH'(i))) ||
                      (busy_r[i] && !(clr_en && (clr_idx == ADDR_WIDTH'(i))));
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/exe_issue_ctrl.sv
// Single-entry issue controller: holds one instruction, blocks it on RAW/WAW
// hazards or a full in-flight window, and supports a drain handshake.
module exe_issue_ctrl #(
  parameter int REG_WIDTH    = 64,
  parameter int REG_COUNT    = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_immflag,
  input  logic [REG_WIDTH-1:0]  in_imm,
  output logic                  iss_valid,
  input  logic                  iss_ready,
  output logic [ADDR_WIDTH-1:0] iss_rs1,
  output logic [ADDR_WIDTH-1:0] iss_rs2,
  output logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_immflag,
  output logic [REG_WIDTH-1:0]  iss_imm,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [REG_COUNT-1:0]  busy_mask,
  output logic [15:0]           stall_cnt,
  output logic                  wb_err
);

  import exe_pkg::*;

  localparam int CNT_W = inflight_w(MAX_INFLIGHT);

  issue_state_e          state_r;
  issue_state_e          state_nxt_s;
  logic [ADDR_WIDTH-1:0] hold_rs1_r;
  logic [ADDR_WIDTH-1:0] hold_rs2_r;
  logic [ADDR_WIDTH-1:0] hold_rd_r;
  logic                  hold_immflag_r;
  logic [REG_WIDTH-1:0]  hold_imm_r;
  logic [CNT_W-1:0]      inflight_r;
  logic [15:0]           stall_cnt_r;
  logic                  wb_err_r;
  logic                  drain_done_r;
  logic                  drain_armed_r;

  logic                  hold_vld_s;
  logic                  inflight_full_s;
  logic                  hazard_s;
  logic                  iss_valid_s;
  logic                  issue_s;
  logic                  in_ready_s;
  logic                  load_s;
  logic                  wb_ok_s;
  logic                  drain_go_s;
  logic                  drain_exit_s;
  logic                  sb_set_s;
  logic [REG_COUNT-1:0]  busy_s;

  // Hazard detection, handshake qualification and drain conditions
  always_comb begin
    hold_vld_s      = (state_r == ST_HOLD);
    inflight_full_s = (inflight_r == CNT_W'(MAX_INFLIGHT));
    hazard_s        = busy_s[hold_rs1_r] | busy_s[hold_rs2_r] | busy_s[hold_rd_r] | inflight_full_s;
    iss_valid_s     = hold_vld_s & ~hazard_s & ~rst;
    issue_s         = iss_valid_s & iss_ready;
    in_ready_s      = ~rst & (state_r != ST_DRAIN) & ~drain_req & (~hold_vld_s | issue_s);
    load_s          = in_valid & in_ready_s;
    // A writeback with nothing in flight is an error and must not touch the counters
    wb_ok_s         = wb_valid & (inflight_r != '0);
    // Drain starts once the hold is (or is about to become) empty; re-arms only after drain_req drops
    drain_go_s      = drain_req & drain_armed_r & (~hold_vld_s | issue_s);
    drain_exit_s    = (state_r == ST_DRAIN) & (inflight_r == '0);
    sb_set_s        = issue_s & (hold_rd_r != '0);
  end

  // Next-state logic for the hold/drain FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (drain_go_s) begin
          state_nxt_s = ST_DRAIN;
        end else if (load_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (issue_s && drain_go_s) begin
          state_nxt_s = ST_DRAIN;
        end else if (issue_s && !load_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (drain_exit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Holding register payload, captured on every accepted instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_rs1_r     <= '0;
      hold_rs2_r     <= '0;
      hold_rd_r      <= '0;
      hold_immflag_r <= 1'b0;
      hold_imm_r     <= '0;
    end else if (load_s) begin
      hold_rs1_r     <= in_rs1;
      hold_rs2_r     <= in_rs2;
      hold_rd_r      <= in_rd;
      hold_immflag_r <= in_immflag;
      hold_imm_r     <= in_imm;
    end
  end

  // In-flight counter: issue and accepted writeback in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= '0;
    end else begin
      case ({issue_s, wb_ok_s})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Saturating count of cycles where a held instruction fails to issue
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (hold_vld_s && !issue_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  // Sticky error for writebacks arriving with nothing in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err_r <= 1'b0;
    end else if (wb_valid && !wb_ok_s) begin
      wb_err_r <= 1'b1;
    end
  end

  // One-cycle drain completion pulse and re-arm tracking for the level drain request
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_done_r  <= 1'b0;
      drain_armed_r <= 1'b1;
    end else begin
      drain_done_r <= drain_exit_s;
      if (drain_exit_s) begin
        drain_armed_r <= 1'b0;
      end else if (!drain_req) begin
        drain_armed_r <= 1'b1;
      end
    end
  end

  exe_scoreboard #(
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (sb_set_s),
    .set_idx (hold_rd_r),
    .clr_en  (wb_ok_s),
    .clr_idx (wb_rd),
    .busy    (busy_s)
  );

  assign in_ready    = in_ready_s;
  assign iss_valid   = iss_valid_s;
  assign iss_rs1     = hold_rs1_r;
  assign iss_rs2     = hold_rs2_r;
  assign iss_rd      = hold_rd_r;
  assign iss_immflag = hold_immflag_r;
  assign iss_imm     = hold_imm_r;
  assign busy_mask   = busy_s;
  assign stall_cnt   = stall_cnt_r;
  assign wb_err      = wb_err_r;
  assign drain_done  = drain_done_r;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Testbench for exe_issue_ctrl: vector table, directed corner sequences and a
// randomized run, all cross-checked every cycle against a behavioural model.
module tb_exe_issue_ctrl;

  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_immflag, iss_ready, wb_valid, drain_req;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;
  logic [63:0] in_imm;
  logic        in_ready, iss_valid, iss_immflag, drain_done, wb_err;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [63:0] iss_imm;
  logic [31:0] busy_mask;
  logic [15:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  exe_issue_ctrl #(.REG_WIDTH(64), .REG_COUNT(32), .ADDR_WIDTH(5), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_immflag(in_immflag), .in_imm(in_imm),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_immflag(iss_immflag), .iss_imm(iss_imm),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .drain_req(drain_req), .drain_done(drain_done), .busy_mask(busy_mask),
    .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          model_on = 1'b0;
  bit          m_hv, m_if, m_err, m_drain, m_armed, m_done;
  bit [4:0]    m_rs1, m_rs2, m_rd;
  bit [63:0]   m_imm;
  bit [31:0]   m_busy;            // registers with a pending writeback
  int          m_infl, m_stall;
  logic [4:0]  outq[$];           // destinations issued and not yet written back

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at the negedge: compares outputs with the model, then advances the model one cycle
  task automatic model_step();
    bit haz, e_iv, e_rdy, issue, wb_ok, done_nxt;
    haz   = m_busy[m_rs1] || m_busy[m_rs2] || m_busy[m_rd] || (m_infl == MAXI);
    e_iv  = !rst && m_hv && !haz;
    issue = e_iv && iss_ready;
    e_rdy = !rst && !m_drain && !drain_req && (!m_hv || issue);
    if (model_on) begin
      chk("m_in_ready", in_ready, e_rdy);
      chk("m_iss_valid", iss_valid, e_iv);
      chk("m_busy_mask", busy_mask, m_busy);
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_wb_err", wb_err, m_err);
      chk("m_drain_done", drain_done, m_done);
      if (m_hv) chk("m_iss_fields", {iss_rs1, iss_rs2, iss_rd, iss_immflag, iss_imm},
                    {m_rs1, m_rs2, m_rd, m_if, m_imm});
    end
    if (rst) begin
      m_hv = 0; m_busy = '0; m_infl = 0; m_stall = 0; m_err = 0;
      m_drain = 0; m_armed = 1; m_done = 0;
      outq.delete();
    end else begin
      wb_ok = wb_valid && (m_infl > 0);
      if (wb_valid && !wb_ok) m_err = 1;
      if (wb_ok) m_busy[wb_rd] = 1'b0;
      if (issue) begin
        if (m_rd != 0) m_busy[m_rd] = 1'b1;
        outq.push_back(m_rd);
      end
      if (m_hv && !issue && m_stall < 65535) m_stall++;
      done_nxt = m_drain && (m_infl == 0);
      if (done_nxt) m_drain = 0;
      else if (!m_drain && drain_req && m_armed && (!m_hv || issue)) m_drain = 1;
      if (done_nxt) m_armed = 0;
      else if (!drain_req) m_armed = 1;
      m_infl = m_infl + (issue ? 1 : 0) - (wb_ok ? 1 : 0);
      m_done = done_nxt;
      if (in_valid && e_rdy) begin
        m_hv = 1; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_if = in_immflag; m_imm = in_imm;
      end else if (issue) begin
        m_hv = 0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic edge_();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
  endtask

  task automatic op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    in_valid = 1'b1; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_immflag = rd[0]; in_imm = {32'hC0DE_0000, 27'd0, rd};
  endtask

  task automatic do_reset();
    idle(); drain_req = 1'b0; iss_ready = 1'b0; rst = 1'b1;
    at_neg();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_iss_valid", iss_valid, 1'b0);
    edge_();
    rst = 1'b0;
    model_on = 1'b1;
  endtask

  // Five independent ops with no writeback: four issue, the fifth waits for one retirement
  task automatic fill5(input string tag);
    iss_ready = 1'b1; wb_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      op(5'(k), 5'd0, 5'd0);
      at_neg();
      chk($sformatf("%s_rdy%0d", tag, k), in_ready, 1'b1);
      if (k > 1) begin
        chk($sformatf("%s_iv%0d", tag, k), iss_valid, 1'b1);
        chk($sformatf("%s_rd%0d", tag, k), iss_rd, 5'(k - 1));
      end
      edge_();
    end
    op(5'd6, 5'd0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk($sformatf("%s_held_iv", tag), iss_valid, 1'b0);
      chk($sformatf("%s_held_rdy", tag), in_ready, 1'b0);
      edge_();
    end
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd1;
    at_neg();
    chk($sformatf("%s_wb_iv", tag), iss_valid, 1'b0);
    edge_();
    wb_valid = 1'b0;
    at_neg();
    chk($sformatf("%s_5th_iv", tag), iss_valid, 1'b1);
    chk($sformatf("%s_5th_rd", tag), iss_rd, 5'd5);
    edge_();
  endtask

  typedef struct {
    bit        iv;  bit [4:0] rd, rs1, rs2;
    bit        wv;  bit [4:0] wrd;
    bit        e_rdy, e_iv; bit [4:0] e_rd; bit [31:0] e_busy; bit e_err;
  } vec_t;

  vec_t tbl[11];
  int   pulses, pulse_at, idx;

  initial begin
    rst = 1'b1; idle(); drain_req = 1'b0; iss_ready = 1'b0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_immflag = 1'b0; in_imm = 64'd0;

    // iv rd rs1 rs2 | wv wrd | rdy iv rd busy err
    tbl[0]  = '{1, 1, 2, 3, 0, 0, 1, 0, 0, 32'h0000_0000, 0};  // r1 = r2 + r3 enters
    tbl[1]  = '{1, 4, 5, 6, 0, 0, 1, 1, 1, 32'h0000_0000, 0};  // r1 issues, r4 enters
    tbl[2]  = '{0, 0, 0, 0, 1, 1, 1, 1, 4, 32'h0000_0002, 0};  // r4 issues back-to-back, r1 retires
    tbl[3]  = '{0, 0, 0, 0, 1, 4, 1, 0, 0, 32'h0000_0010, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 0};
    tbl[5]  = '{1, 2, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 0};
    tbl[6]  = '{1, 3, 0, 0, 0, 0, 1, 1, 2, 32'h0000_0000, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 3, 1, 1, 3, 32'h0000_0004, 0};  // issue rd3 with wb rd3 together
    tbl[8]  = '{0, 0, 0, 0, 1, 2, 1, 0, 0, 32'h0000_000C, 0};  // set wins, one op still in flight
    tbl[9]  = '{0, 0, 0, 0, 1, 3, 1, 0, 0, 32'h0000_0008, 0};  // nothing left in flight: ignored
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0008, 1};

    do_reset();
    chk("reset_busy", busy_mask, 32'h0);
    chk("reset_stall", stall_cnt, 16'h0);
    chk("reset_err", wb_err, 1'b0);
    chk("reset_done", drain_done, 1'b0);

    // Vector table: independent stream and same-cycle issue/writeback
    iss_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (tbl[k].iv) op(tbl[k].rd, tbl[k].rs1, tbl[k].rs2);
      else in_valid = 1'b0;
      wb_valid = tbl[k].wv; wb_rd = tbl[k].wrd;
      at_neg();
      chk($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].e_rdy);
      chk($sformatf("tbl%0d_iss_valid", k), iss_valid, tbl[k].e_iv);
      if (tbl[k].e_iv) chk($sformatf("tbl%0d_iss_rd", k), iss_rd, tbl[k].e_rd);
      chk($sformatf("tbl%0d_busy", k), busy_mask, tbl[k].e_busy);
      chk($sformatf("tbl%0d_stall", k), stall_cnt, 16'h0);
      chk($sformatf("tbl%0d_err", k), wb_err, tbl[k].e_err);
      edge_();
    end

    // RAW: r7 = r1 + r0 waits for r1's writeback, five stall cycles
    do_reset();
    iss_ready = 1'b1;
    op(5'd1, 5'd2, 5'd3); at_neg(); edge_();
    op(5'd7, 5'd1, 5'd0); at_neg();
    chk("raw_first_iv", iss_valid, 1'b1);
    chk("raw_first_rd", iss_rd, 5'd1);
    edge_();
    in_valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      wb_valid = (s == 4); wb_rd = 5'd1;
      at_neg();
      chk($sformatf("raw_stall%0d_iv", s), iss_valid, 1'b0);
      chk($sformatf("raw_stall%0d_cnt", s), stall_cnt, 16'(s));
      edge_();
    end
    wb_valid = 1'b0;
    at_neg();
    chk("raw_dep_iv", iss_valid, 1'b1);
    chk("raw_dep_rd", iss_rd, 5'd7);
    chk("raw_dep_stall", stall_cnt, 16'd5);
    edge_();
    at_neg();
    chk("raw_after_iv", iss_valid, 1'b0);
    chk("raw_after_stall", stall_cnt, 16'd5);
    edge_();

    // In-flight limit, then reset in the middle of activity, then a spurious writeback
    do_reset();
    fill5("lim");
    rst = 1'b1; op(5'd9, 5'd0, 5'd0); wb_valid = 1'b1; wb_rd = 5'd2; iss_ready = 1'b1;
    at_neg();
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_iss_valid", iss_valid, 1'b0);
    edge_();
    rst = 1'b0; idle(); wb_valid = 1'b1; wb_rd = 5'd2;
    at_neg();
    chk("postrst_busy", busy_mask, 32'h0);
    chk("postrst_stall", stall_cnt, 16'h0);
    chk("postrst_err", wb_err, 1'b0);
    chk("postrst_done", drain_done, 1'b0);
    chk("postrst_iv", iss_valid, 1'b0);
    chk("postrst_rdy", in_ready, 1'b1);
    edge_();
    wb_valid = 1'b0;
    at_neg();
    chk("spur_err", wb_err, 1'b1);
    chk("spur_busy", busy_mask, 32'h0);
    edge_();
    fill5("spur");   // only four may issue if the counter stayed at zero

    // Drain with two in flight and one held
    do_reset();
    iss_ready = 1'b1;
    op(5'd1, 5'd0, 5'd0); at_neg(); edge_();
    op(5'd2, 5'd0, 5'd0); at_neg(); edge_();
    op(5'd3, 5'd0, 5'd0); at_neg(); edge_();
    op(5'd4, 5'd0, 5'd0); iss_ready = 1'b0; drain_req = 1'b1;
    at_neg();
    chk("drain_req_rdy", in_ready, 1'b0);
    chk("drain_req_iv", iss_valid, 1'b1);
    edge_();
    iss_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd1;
    at_neg();
    chk("drain_held_iv", iss_valid, 1'b1);
    chk("drain_held_rd", iss_rd, 5'd3);
    chk("drain_held_rdy", in_ready, 1'b0);
    edge_();
    wb_rd = 5'd2;
    at_neg();
    chk("drain_wb2_rdy", in_ready, 1'b0);
    chk("drain_wb2_iv", iss_valid, 1'b0);
    edge_();
    wb_rd = 5'd3;
    at_neg();
    chk("drain_wb3_done", drain_done, 1'b0);
    edge_();
    wb_valid = 1'b0; pulses = 0; pulse_at = -1;
    for (int c = 0; c < 8; c++) begin
      at_neg();
      if (drain_done) begin pulses++; pulse_at = c; end
      chk($sformatf("drain_wait%0d_rdy", c), in_ready, 1'b0);
      edge_();
    end
    chk("drain_pulses", pulses, 1);
    chk("drain_pulse_cycle", pulse_at, 1);
    in_valid = 1'b0; drain_req = 1'b0;
    at_neg();
    chk("drain_release_rdy", in_ready, 1'b1);
    edge_();
    drain_req = 1'b1; pulses = 0; pulse_at = -1;
    for (int c = 0; c < 6; c++) begin
      at_neg();
      if (drain_done) begin pulses++; pulse_at = c; end
      edge_();
    end
    chk("redrain_pulses", pulses, 1);
    chk("redrain_pulse_cycle", pulse_at, 2);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      in_valid   = ($urandom_range(0, 9) < 6);
      in_rs1     = 5'($urandom_range(0, 7));
      in_rs2     = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 7));
      in_immflag = 1'($urandom_range(0, 1));
      in_imm     = {$urandom, $urandom};
      iss_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) drain_req = !drain_req;
      wb_valid = 1'b0; wb_rd = 5'd0;
      if (outq.size() > 0 && $urandom_range(0, 9) < 3) begin
        idx = int'($urandom_range(0, outq.size() - 1));
        wb_valid = 1'b1; wb_rd = outq[idx];
        outq.delete(idx);
      end else if ($urandom_range(0, 99) == 0) begin
        wb_valid = 1'b1; wb_rd = 5'($urandom_range(0, 31));
      end
      at_neg();
      edge_();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
